// File: rtl/fetch_buffered_if.sv
// fetch_buffered_if: groups the IMEM request bus, the redirect inputs and the
// ID-side queue handshake of the fetch front end.
// master = fetch unit side, slave = environment (IMEM, CSR/EXE, decode).
interface fetch_buffered_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_ack_i;
    logic [31:0]     imem_rdata_i;
    logic            imem_kill_o;

    logic            csr_redirect_i;
    logic [XLEN-1:0] csr_pc_i;
    logic            exe_redirect_i;
    logic [XLEN-1:0] exe_pc_i;

    logic            id_valid_o;
    logic            id_ready_i;
    logic [31:0]     id_instr_o;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_pc_next_o;
    logic            id_exc_req_o;

    modport master (
        output imem_req_o, imem_addr_o, imem_kill_o,
        input  imem_ack_i, imem_rdata_i,
        input  csr_redirect_i, csr_pc_i, exe_redirect_i, exe_pc_i,
        output id_valid_o, id_instr_o, id_pc_o, id_pc_next_o, id_exc_req_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, imem_kill_o,
        output imem_ack_i, imem_rdata_i,
        output csr_redirect_i, csr_pc_i, exe_redirect_i, exe_pc_i,
        input  id_valid_o, id_instr_o, id_pc_o, id_pc_next_o, id_exc_req_o,
        output id_ready_i
    );
endinterface

// File: rtl/fetch_buffered.sv
// fetch_buffered: instruction-fetch front end with a DEPTH-entry prefetch
// queue. Generates the PC, keeps at most one IMEM request outstanding,
// buffers responses and hands them to decode over valid/ready.
// Optional feature macro: FETCH_JAL_PREDICT_EN (static JAL steering at fill).
module fetch_buffered #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_buffered_if.master bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {ST_RUN, ST_EXC, ST_HALT} state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic            exc;
    } entry_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic            pending_reg, pending_next;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_after_pop;
    logic [CW-1:0]   count_reg, count_after_pop;
    entry_t          mem [DEPTH];
    entry_t          head_reg;
    entry_t          push_entry;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            has_space, aligned, pop;
    logic            issue, exc_push, req, ack_take, push;
    logic [XLEN-1:0] seq_pc, ack_target;
`ifdef FETCH_JAL_PREDICT_EN
    logic [20:0]     jal_imm;
    logic [XLEN-1:0] jal_target;
`endif

    // Redirect selection: CSR takes priority over EXE
    always_comb begin
        redirect    = bus.csr_redirect_i | bus.exe_redirect_i;
        redirect_pc = bus.csr_redirect_i ? bus.csr_pc_i : bus.exe_pc_i;
    end

    // Queue status and pop handshake
    always_comb begin
        has_space        = count_reg < CW'(DEPTH);
        aligned          = (fetch_pc_reg[1:0] == 2'b00);
        pop              = (count_reg != '0) && bus.id_ready_i;
        rd_ptr_after_pop = rd_ptr_reg + PW'(pop);
        count_after_pop  = count_reg - CW'(pop);
    end

    // Address following the current fetch: sequential, or JAL target if predicted
    always_comb begin
        seq_pc = fetch_pc_reg + XLEN'(4);
`ifdef FETCH_JAL_PREDICT_EN
        jal_imm    = {bus.imem_rdata_i[31], bus.imem_rdata_i[19:12], bus.imem_rdata_i[20],
                      bus.imem_rdata_i[30:21], 1'b0};
        jal_target = fetch_pc_reg + {{(XLEN-21){jal_imm[20]}}, jal_imm};
        ack_target = (bus.imem_rdata_i[6:0] == 7'b1101111) ? jal_target : seq_pc;
`else
        ack_target = seq_pc;
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= ST_RUN;
        else        state_reg <= state_next;
    end

    // FSM next state: misaligned PC parks the fetcher until a redirect
    always_comb begin
        state_next = state_reg;
        if (redirect) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN:  if (!aligned && !pending_reg) state_next = ST_EXC;
                ST_EXC:  if (has_space) state_next = ST_HALT;
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_RUN;
            endcase
        end
    end

    // FSM outputs: issue a request, or push the misaligned-exception marker.
    // An ack in the same cycle as a fresh issue counts as answering it.
    always_comb begin
        issue    = 1'b0;
        exc_push = 1'b0;
        if (rst_n && !redirect) begin
            case (state_reg)
                ST_RUN:  issue    = !pending_reg && aligned && has_space;
                ST_EXC:  exc_push = has_space;
                default: ;
            endcase
        end
        req      = rst_n && !redirect && (pending_reg || issue);
        ack_take = req && bus.imem_ack_i;
        push     = ack_take || exc_push;
    end

    // Entry written on a push: fetched word, or a NOP carrying the exception
    always_comb begin
        if (ack_take) begin
            push_entry = '{instr: bus.imem_rdata_i, pc: fetch_pc_reg,
                           pc_next: ack_target, exc: 1'b0};
        end else begin
            push_entry = '{instr: NOP, pc: fetch_pc_reg,
                           pc_next: fetch_pc_reg, exc: 1'b1};
        end
    end

    // Fetch PC and outstanding-request flag next values
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        pending_next  = pending_reg;
        if (redirect) begin
            fetch_pc_next = redirect_pc;
            pending_next  = 1'b0;
        end else begin
            if (ack_take) fetch_pc_next = ack_target;
            pending_next = req && !ack_take;
        end
    end

    // Fetch PC and pending flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_reg <= PC_RESET;
            pending_reg  <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            pending_reg  <= pending_next;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything
    always_ff @(posedge clk) begin
        if (!rst_n || redirect) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            rd_ptr_reg <= rd_ptr_after_pop;
            count_reg  <= count_after_pop + CW'(push);
        end
    end

    // Queue storage write port (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_entry;
    end

    // Registered head read; a push into an otherwise empty queue is forwarded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg <= '{instr: NOP, pc: '0, pc_next: '0, exc: 1'b0};
        end else if (!redirect) begin
            if (push && count_after_pop == '0) head_reg <= push_entry;
            else if (count_after_pop != '0)    head_reg <= mem[rd_ptr_after_pop];
        end
    end

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = fetch_pc_reg;
    assign bus.imem_kill_o  = redirect;
    assign bus.id_valid_o   = (count_reg != '0);
    assign bus.id_instr_o   = head_reg.instr;
    assign bus.id_pc_o      = head_reg.pc;
    assign bus.id_pc_next_o = head_reg.pc_next;
    assign bus.id_exc_req_o = head_reg.exc;
endmodule

// File: tb/tb_fetch_buffered.sv
// tb_fetch_buffered: directed tests for fetch_buffered (DEPTH=4, PC_RESET=0).
// Expected JAL behaviour follows FETCH_JAL_PREDICT_EN as built.
`timescale 1ns/1ps
module tb_fetch_buffered;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    fetch_buffered_if #(.XLEN(32)) bus ();

    fetch_buffered #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addi(input int k);
        addi = {k[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acknowledge whatever request is on the bus this cycle with the given word
    task automatic respond(input logic [31:0] word);
        bus.imem_ack_i = 1'b0;
        #1;
        bus.imem_ack_i   = bus.imem_req_o;
        bus.imem_rdata_i = word;
        #1;
    endtask

    // One-cycle redirect pulse; returns in the following cycle
    task automatic do_redirect(input logic use_csr, input logic [31:0] pc);
        bus.imem_ack_i = 1'b0;
        if (use_csr) begin bus.csr_redirect_i = 1'b1; bus.csr_pc_i = pc; end
        else         begin bus.exe_redirect_i = 1'b1; bus.exe_pc_i = pc; end
        #2;
        tick();
        bus.csr_redirect_i = 1'b0;
        bus.exe_redirect_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        #1;
        n_vec++; if (bus.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.imem_req_o); end
        n_vec++; if (bus.imem_kill_o !== 1'b0) begin n_bad++; $display("FAIL rst_kill got %b want 0", bus.imem_kill_o); end
        n_vec++; if (bus.id_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.id_valid_o); end
        n_vec++; if (bus.id_instr_o !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_instr got %h want 00000013", bus.id_instr_o); end
        n_vec++; if (bus.id_pc_o !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", bus.id_pc_o); end
        n_vec++; if (bus.id_pc_next_o !== 32'h0) begin n_bad++; $display("FAIL rst_pc_next got %h want 0", bus.id_pc_next_o); end
        n_vec++; if (bus.id_exc_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_exc got %b want 0", bus.id_exc_req_o); end
        n_vec++; if (bus.imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus.imem_addr_o); end
        $display("reset checked");
        rst_n = 1'b1;
    endtask

    // Ack every cycle, ID always ready: one instruction per cycle
    task automatic test_sequential();
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            respond(addi(i));
            n_vec++; if (bus.imem_req_o !== 1'b1) begin n_bad++; $display("FAIL seq_req c%0d got %b want 1", i, bus.imem_req_o); end
            n_vec++; if (bus.imem_addr_o !== 32'(4*i)) begin n_bad++; $display("FAIL seq_addr c%0d got %h want %h", i, bus.imem_addr_o, 32'(4*i)); end
            if (i > 0) begin
                n_vec++; if (bus.id_valid_o !== 1'b1) begin n_bad++; $display("FAIL seq_valid c%0d got %b want 1", i, bus.id_valid_o); end
                n_vec++; if (bus.id_pc_o !== 32'(4*(i-1))) begin n_bad++; $display("FAIL seq_pc c%0d got %h want %h", i, bus.id_pc_o, 32'(4*(i-1))); end
                n_vec++; if (bus.id_pc_next_o !== 32'(4*i)) begin n_bad++; $display("FAIL seq_pc_next c%0d got %h want %h", i, bus.id_pc_next_o, 32'(4*i)); end
                n_vec++; if (bus.id_instr_o !== addi(i-1)) begin n_bad++; $display("FAIL seq_instr c%0d got %h want %h", i, bus.id_instr_o, addi(i-1)); end
            end
            $display("seq c%0d req addr=%h head pc=%h instr=%h", i, bus.imem_addr_o, bus.id_pc_o, bus.id_instr_o);
            tick();
        end
        bus.imem_ack_i = 1'b0;
    endtask

    // ID stalled: queue fills to 4, requests stop, resume after the first pop
    task automatic test_backpressure();
        int reqs;
        reqs = 0;
        bus.id_ready_i = 1'b0;
        do_redirect(1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            respond(addi(i));
            if (bus.imem_req_o === 1'b1) reqs++;
            if (i < 4) begin
                n_vec++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'(4*i)) begin n_bad++; $display("FAIL bp_req c%0d got req=%b addr=%h want req=1 addr=%h", i, bus.imem_req_o, bus.imem_addr_o, 32'(4*i)); end
            end else begin
                n_vec++; if (bus.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL bp_stop c%0d got %b want 0", i, bus.imem_req_o); end
            end
            if (i > 0) begin
                n_vec++; if (bus.id_pc_o !== 32'h0) begin n_bad++; $display("FAIL bp_hold c%0d got %h want 0", i, bus.id_pc_o); end
            end
            $display("bp c%0d req=%b addr=%h head pc=%h", i, bus.imem_req_o, bus.imem_addr_o, bus.id_pc_o);
            tick();
        end
        n_vec++; if (reqs != 4) begin n_bad++; $display("FAIL bp_count got %0d want 4", reqs); end
        bus.imem_ack_i = 1'b0;
        bus.id_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_vec++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'(4*k) || bus.id_instr_o !== addi(k)) begin n_bad++; $display("FAIL bp_pop%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, bus.id_valid_o, bus.id_pc_o, bus.id_instr_o, 32'(4*k), addi(k)); end
            if (k == 0) begin
                n_vec++; if (bus.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL bp_full_req got %b want 0", bus.imem_req_o); end
            end else begin
                n_vec++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin n_bad++; $display("FAIL bp_resume k%0d got req=%b addr=%h want req=1 addr=00000010", k, bus.imem_req_o, bus.imem_addr_o); end
            end
            $display("bp pop pc=%h instr=%h", bus.id_pc_o, bus.id_instr_o);
            tick();
        end
        #2;
        n_vec++; if (bus.id_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", bus.id_valid_o); end
        bus.id_ready_i = 1'b0;
    endtask

    // Redirect with a request pending and 2 entries queued; late ack dropped
    task automatic test_redirect_kill();
        bus.id_ready_i = 1'b0;
        do_redirect(1'b0, 32'h0);
        respond(addi(0)); tick();
        respond(addi(1)); tick();
        bus.imem_ack_i = 1'b0; #2;
        n_vec++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin n_bad++; $display("FAIL rk_pending got req=%b addr=%h want req=1 addr=00000008", bus.imem_req_o, bus.imem_addr_o); end
        tick();
        bus.exe_redirect_i = 1'b1; bus.exe_pc_i = 32'h100;
        bus.imem_ack_i = 1'b1;     bus.imem_rdata_i = 32'h0aa0_0093;
        #2;
        n_vec++; if (bus.imem_kill_o !== 1'b1) begin n_bad++; $display("FAIL rk_kill got %b want 1", bus.imem_kill_o); end
        n_vec++; if (bus.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rk_req got %b want 0", bus.imem_req_o); end
        n_vec++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h0) begin n_bad++; $display("FAIL rk_two_queued got v=%b pc=%h want v=1 pc=0", bus.id_valid_o, bus.id_pc_o); end
        $display("redirect to 00000100 kill=%b", bus.imem_kill_o);
        tick();
        bus.exe_redirect_i = 1'b0; bus.imem_ack_i = 1'b0;
        #2;
        n_vec++; if (bus.imem_kill_o !== 1'b0) begin n_bad++; $display("FAIL rk_kill_len got %b want 0", bus.imem_kill_o); end
        n_vec++; if (bus.id_valid_o !== 1'b0) begin n_bad++; $display("FAIL rk_flush got %b want 0", bus.id_valid_o); end
        n_vec++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin n_bad++; $display("FAIL rk_newpc got req=%b addr=%h want req=1 addr=00000100", bus.imem_req_o, bus.imem_addr_o); end
        respond(addi(64));
        tick();
        bus.imem_ack_i = 1'b0; #2;
        n_vec++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h100 || bus.id_instr_o !== addi(64)) begin n_bad++; $display("FAIL rk_first got v=%b pc=%h instr=%h want v=1 pc=00000100 instr=%h", bus.id_valid_o, bus.id_pc_o, bus.id_instr_o, addi(64)); end
        $display("after redirect head pc=%h instr=%h", bus.id_pc_o, bus.id_instr_o);
        tick();
    endtask

    // CSR and EXE redirect together: CSR target wins
    task automatic test_priority();
        bus.imem_ack_i = 1'b0;
        bus.csr_redirect_i = 1'b1; bus.csr_pc_i = 32'h200;
        bus.exe_redirect_i = 1'b1; bus.exe_pc_i = 32'h300;
        #2;
        n_vec++; if (bus.imem_kill_o !== 1'b1) begin n_bad++; $display("FAIL pri_kill got %b want 1", bus.imem_kill_o); end
        tick();
        bus.csr_redirect_i = 1'b0; bus.exe_redirect_i = 1'b0;
        #2;
        n_vec++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin n_bad++; $display("FAIL pri_addr got req=%b addr=%h want req=1 addr=00000200", bus.imem_req_o, bus.imem_addr_o); end
        $display("priority redirect fetch addr=%h", bus.imem_addr_o);
        tick();
    endtask

    // Misaligned target: exception entry, no fetch, halt until redirect
    task automatic test_misaligned();
        logic found;
        found = 1'b0;
        bus.id_ready_i = 1'b1;
        do_redirect(1'b0, 32'h102);
        for (int i = 0; i < 6 && !found; i++) begin
            #2;
            n_vec++; if (bus.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL mis_noreq c%0d got %b want 0", i, bus.imem_req_o); end
            if (bus.id_valid_o === 1'b1) found = 1'b1;
            else tick();
        end
        n_vec++;
        if (!found) begin
            n_bad++; $display("FAIL mis_timeout got no valid entry want exc entry within 6 cycles");
        end else if (bus.id_pc_o !== 32'h102 || bus.id_pc_next_o !== 32'h102 || bus.id_exc_req_o !== 1'b1 || bus.id_instr_o !== 32'h13) begin
            n_bad++; $display("FAIL mis_entry got pc=%h pc_next=%h exc=%b instr=%h want 00000102/00000102/1/00000013", bus.id_pc_o, bus.id_pc_next_o, bus.id_exc_req_o, bus.id_instr_o);
        end
        $display("exception entry pc=%h exc=%b", bus.id_pc_o, bus.id_exc_req_o);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_vec++; if (bus.id_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL mis_halt c%0d got v=%b req=%b want 0/0", i, bus.id_valid_o, bus.imem_req_o); end
        end
        tick();
        do_redirect(1'b0, 32'h104);
        #2;
        n_vec++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h104) begin n_bad++; $display("FAIL mis_resume got req=%b addr=%h want req=1 addr=00000104", bus.imem_req_o, bus.imem_addr_o); end
        $display("resume fetch addr=%h", bus.imem_addr_o);
        bus.id_ready_i = 1'b0;
        tick();
    endtask

    // JAL +16 at 0x40: steered only when prediction is built in
    task automatic test_jal();
        logic [31:0] exp_next;
`ifdef FETCH_JAL_PREDICT_EN
        exp_next = 32'h50;
`else
        exp_next = 32'h44;
`endif
        bus.id_ready_i = 1'b0;
        do_redirect(1'b0, 32'h40);
        respond(32'h0100_006F);
        n_vec++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h40) begin n_bad++; $display("FAIL jal_req got req=%b addr=%h want req=1 addr=00000040", bus.imem_req_o, bus.imem_addr_o); end
        tick();
        bus.imem_ack_i = 1'b0; #2;
        n_vec++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== exp_next) begin n_bad++; $display("FAIL jal_next_addr got req=%b addr=%h want req=1 addr=%h", bus.imem_req_o, bus.imem_addr_o, exp_next); end
        n_vec++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h40 || bus.id_pc_next_o !== exp_next || bus.id_instr_o !== 32'h0100_006F) begin n_bad++; $display("FAIL jal_entry got v=%b pc=%h pc_next=%h instr=%h want 1/00000040/%h/0100006f", bus.id_valid_o, bus.id_pc_o, bus.id_pc_next_o, bus.id_instr_o, exp_next); end
        $display("jal entry pc=%h pc_next=%h next fetch=%h", bus.id_pc_o, bus.id_pc_next_o, bus.imem_addr_o);
        tick();
    endtask

    initial begin
        bus.imem_ack_i     = 1'b0;
        bus.imem_rdata_i   = 32'h0;
        bus.csr_redirect_i = 1'b0;
        bus.csr_pc_i       = 32'h0;
        bus.exe_redirect_i = 1'b0;
        bus.exe_pc_i       = 32'h0;
        bus.id_ready_i     = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_kill();
        test_priority();
        test_misaligned();
        test_jal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
